sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_pkg.sv | 13 +
 rtl/sipo_deser.sv | 128 ++++++++++++
 tb/tb_sipo_deser.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared types for the serial-in/parallel-out deserialiser.
// The PARITY state is only present when SIPO_DESER_PARITY_EN is defined.
package sipo_pkg;

    localparam int SIPO_WIDTH_DEF = 4;

`ifdef SIPO_DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} sipo_state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} sipo_state_t;
`endif

endpackage

// File: rtl/sipo_deser.sv
// Deserialises framed bit beats into WIDTH-bit words; optional even parity via SIPO_DESER_PARITY_EN.
// Latency: q/q_valid one cycle after the frame-completing beat (data or parity beat).
// Backpressure: none; idle strobe cycles hold state indefinitely, frame_start mid-frame aborts and restarts.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             par_err
);

    localparam int CW = $clog2(WIDTH + 2);

    sipo_state_t      state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt, q_nxt;
    logic [WIDTH-1:0] shifted, fresh;
    logic             q_valid_nxt, frame_err_nxt;
`ifdef SIPO_DESER_PARITY_EN
    logic             par_err_nxt;
`endif

    // Shift direction decides whether the first beat ends up in the MSB or the LSB.
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {sreg[WIDTH-2:0], sin};
            fresh   = {{(WIDTH-1){1'b0}}, sin};
        end else begin
            shifted = {sin, sreg[WIDTH-1:1]};
            fresh   = {sin, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        sreg_nxt      = sreg;
        q_nxt         = q;
        q_valid_nxt   = 1'b0;
        frame_err_nxt = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
        par_err_nxt   = 1'b0;
`endif
        if (sin_valid && frame_start && state != IDLE) begin
            frame_err_nxt = 1'b1;
            sreg_nxt      = fresh;
            cnt_nxt       = CW'(1);
            state_nxt     = SHIFT;
        end else if (sin_valid) begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        sreg_nxt  = fresh;
                        cnt_nxt   = CW'(1);
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    sreg_nxt = shifted;
                    cnt_nxt  = cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIPO_DESER_PARITY_EN
                        state_nxt = PARITY;
`else
                        q_nxt       = shifted;
                        q_valid_nxt = 1'b1;
                        cnt_nxt     = '0;
                        state_nxt   = IDLE;
`endif
                    end
                end
`ifdef SIPO_DESER_PARITY_EN
                PARITY: begin
                    if (sin == ^sreg) begin
                        q_nxt       = sreg;
                        q_valid_nxt = 1'b1;
                    end else begin
                        par_err_nxt = 1'b1;
                    end
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sreg      <= sreg_nxt;
            q         <= q_nxt;
            q_valid   <= q_valid_nxt;
            frame_err <= frame_err_nxt;
        end
    end

`ifdef SIPO_DESER_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) par_err <= 1'b0;
        else        par_err <= par_err_nxt;
    end
`else
    assign par_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share one beat stream;
// a per-instance queue of expected words is popped whenever q_valid is seen.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst_n, sin, sin_valid, frame_start;
    logic [3:0] q_m, q_l;
    logic       q_valid_m, q_valid_l, busy_m, busy_l;
    logic       frame_err_m, frame_err_l, par_err_m, par_err_l;

    int checks   = 0;
    int failures = 0;
    int fe_cnt_m = 0, fe_cnt_l = 0, pe_cnt = 0;
    logic [3:0] sb_m[$];
    logic [3:0] sb_l[$];
    logic [3:0] q_last_m = 4'h0, q_last_l = 4'h0;
    logic       prev_qv_m = 1'b0, prev_qv_l = 1'b0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
        .frame_start(frame_start), .q(q_m), .q_valid(q_valid_m), .busy(busy_m),
        .frame_err(frame_err_m), .par_err(par_err_m)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
        .frame_start(frame_start), .q(q_l), .q_valid(q_valid_l), .busy(busy_l),
        .frame_err(frame_err_l), .par_err(par_err_l)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] d);
        return {d[0], d[1], d[2], d[3]};
    endfunction

    // d[3] is the first beat on the wire.
    task automatic expect_word(input logic [3:0] d);
        sb_m.push_back(d);
        sb_l.push_back(rev4(d));
    endtask

    task automatic beat(input logic b, input logic fs);
        sin         = b;
        frame_start = fs;
        sin_valid   = 1'b1;
        @(posedge clk);
        #1;
        sin_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic finish_frame(input string tag, input logic [3:0] d);
`ifdef SIPO_DESER_PARITY_EN
        beat(^d, 1'b0);
`endif
        chk({tag, "_qv_lat_m"}, q_valid_m, 1'b1);
        chk({tag, "_q_m"}, q_m, d);
        chk({tag, "_q_l"}, q_l, rev4(d));
    endtask

    task automatic send_frame(input string tag, input logic [3:0] d, input bit gaps);
        expect_word(d);
        for (int i = 3; i >= 0; i--) begin
            beat(d[i], i == 3);
            if (i == 3) chk({tag, "_busy"}, busy_m, 1'b1);
            if (gaps && i > 0 && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        finish_frame(tag, d);
    endtask

    always @(negedge clk) begin
        if (q_valid_m) begin
            chk("sb_m_pending", sb_m.size() != 0, 1'b1);
            if (sb_m.size() != 0) chk("sb_q_m", q_m, sb_m.pop_front());
        end
        if (q_valid_l) begin
            chk("sb_l_pending", sb_l.size() != 0, 1'b1);
            if (sb_l.size() != 0) chk("sb_q_l", q_l, sb_l.pop_front());
        end
        if (prev_qv_m) chk("qv_double_m", q_valid_m, 1'b0);
        if (prev_qv_l) chk("qv_double_l", q_valid_l, 1'b0);
        if (!rst_n) begin
            q_last_m = 4'h0;
            q_last_l = 4'h0;
        end else begin
            if (q_valid_m) q_last_m = q_m; else chk("q_hold_m", q_m, q_last_m);
            if (q_valid_l) q_last_l = q_l; else chk("q_hold_l", q_l, q_last_l);
        end
        prev_qv_m = q_valid_m;
        prev_qv_l = q_valid_l;
        if (frame_err_m) fe_cnt_m++;
        if (frame_err_l) fe_cnt_l++;
        if (par_err_m) pe_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] d;
        rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; frame_start = 1'b0;
        idle(2);
        chk("rst_q_m", q_m, 4'h0);
        chk("rst_q_l", q_l, 4'h0);
        chk("rst_qv", q_valid_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_fe", frame_err_m, 1'b0);
        chk("rst_pe", par_err_m, 1'b0);
        rst_n = 1'b1;
        idle(1);

        // Beat with frame_start=0 in IDLE is ignored.
        beat(1'b1, 1'b0);
        chk("idle_ignore_busy", busy_m, 1'b0);

        send_frame("basic", 4'b1011, 1'b0);
        chk("basic_idle_after", busy_m, 1'b0);
        idle(1);
        chk("basic_qv_pulse", q_valid_m, 1'b0);

        // Gap of three idle cycles mid-frame.
        expect_word(4'b1001);
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("gap_busy", busy_m, 1'b1);
        end
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        finish_frame("gap", 4'b1001);

        // Mid-frame restart.
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        chk("restart_fe_m", frame_err_m, 1'b1);
        chk("restart_fe_l", frame_err_l, 1'b1);
        chk("restart_q_prior", q_m, 4'b1001);
        chk("restart_busy", busy_m, 1'b1);
        beat(1'b1, 1'b0);
        idle(1);
        chk("restart_fe_pulse", frame_err_m, 1'b0);
        beat(1'b1, 1'b0);
        expect_word(4'b0110);
        beat(1'b0, 1'b0);
        finish_frame("restart", 4'b0110);

        // frame_start on the frame-completing beat aborts instead of completing.
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        chk("abort_last_fe", frame_err_m, 1'b1);
        chk("abort_last_qv", q_valid_m, 1'b0);
        chk("abort_last_q", q_m, 4'b0110);
        expect_word(4'b1011);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        finish_frame("abort_last", 4'b1011);

        // Reset mid-frame, with a frame_start beat during reset.
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        rst_n = 1'b0;
        beat(1'b1, 1'b1);
        chk("mid_rst_fe", frame_err_m, 1'b0);
        chk("mid_rst_qv", q_valid_m, 1'b0);
        chk("mid_rst_busy", busy_m, 1'b0);
        chk("mid_rst_q", q_m, 4'h0);
        beat(1'b0, 1'b0);
        rst_n = 1'b1;
        send_frame("post_rst", 4'b0101, 1'b0);

`ifdef SIPO_DESER_PARITY_EN
        // Wrong parity: error pulse, q untouched, no q_valid.
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        chk("par_wait_busy", busy_m, 1'b1);
        beat(1'b0, 1'b0);
        chk("par_bad_pe", par_err_m, 1'b1);
        chk("par_bad_qv", q_valid_m, 1'b0);
        chk("par_bad_q", q_m, 4'b0101);
        chk("par_bad_idle", busy_m, 1'b0);
`endif

        for (int k = 0; k < 8; k++) begin
            d = 4'($urandom);
            send_frame("rand", d, 1'b1);
            idle($urandom_range(0, 2));
        end

        idle(2);
        chk("sb_m_drained", sb_m.size(), 0);
        chk("sb_l_drained", sb_l.size(), 0);
        chk("fe_count_m", fe_cnt_m, 2);
        chk("fe_count_l", fe_cnt_l, 2);
`ifdef SIPO_DESER_PARITY_EN
        chk("pe_count", pe_cnt, 1);
`else
        chk("pe_count", pe_cnt, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
